// File: rtl/pitch_sched_pkg.sv
// rtl/pitch_sched_pkg.sv - shared buffer-state and stage-FSM types for the ping-pong scheduler
package pitch_sched_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_FULL  = 2'd1,
    BUF_BUSY  = 2'd2
  } buf_state_t;

  typedef enum logic {
    STAGE_IDLE = 1'b0,
    STAGE_BUSY = 1'b1
  } stage_state_t;

endpackage

// File: rtl/stage_handshake.sv
// rtl/stage_handshake.sv - idle/busy start-done handshake for one processing stage
module stage_handshake
  import pitch_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start_ok,
  input  logic done,
  output logic go,
  output logic launch,
  output logic finish
);

  stage_state_t state;

  // done while idle is a stray pulse and is dropped here
  assign launch = (state == STAGE_IDLE) && start_ok;
  assign finish = (state == STAGE_BUSY) && done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STAGE_IDLE;
      go    <= 1'b0;
    end else begin
      go <= launch;
      case (state)
        STAGE_IDLE: if (launch) state <= STAGE_BUSY;
        STAGE_BUSY: if (finish) state <= STAGE_IDLE;
        default:    state <= STAGE_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pingpong_stage_sched.sv
// rtl/pingpong_stage_sched.sv - two-window ping-pong scheduler for cart_to_polar/scaler/polar_to_cart; stats under SCHED_STATS_EN
module pingpong_stage_sched
  import pitch_sched_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c2p_done,
  output logic             c2p_ready,
  output logic             c2p_idx,
  output logic             scaler_go,
  output logic             scaler_win,
  input  logic             scaler_done,
  input  logic [7:0]       shift_amt_in,
  output logic [7:0]       shift_amt_out,
  output logic             p2c_go,
  output logic             p2c_buf,
  input  logic             p2c_done,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] win_cnt
);

  buf_state_t pre_q  [0:1];
  buf_state_t post_q [0:1];
  logic       sc_idx;
  logic       p2c_idx;

  logic sc_start_ok, sc_launch, sc_finish;
  logic pc_start_ok, pc_launch, pc_finish;
  logic c2p_accept;

  assign c2p_ready   = (pre_q[c2p_idx] == BUF_EMPTY);
  assign c2p_accept  = c2p_done && c2p_ready;
  assign sc_start_ok = (pre_q[sc_idx] == BUF_FULL) && (post_q[sc_idx] == BUF_EMPTY);
  assign pc_start_ok = (post_q[p2c_idx] == BUF_FULL);

  stage_handshake u_scaler_hs (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_ok (sc_start_ok),
    .done     (scaler_done),
    .go       (scaler_go),
    .launch   (sc_launch),
    .finish   (sc_finish)
  );

  stage_handshake u_p2c_hs (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_ok (pc_start_ok),
    .done     (p2c_done),
    .go       (p2c_go),
    .launch   (pc_launch),
    .finish   (pc_finish)
  );

  // Each event only touches a buffer in a state no other same-cycle event can target,
  // so the updates below never collide on one element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q[0]      <= BUF_EMPTY;
      pre_q[1]      <= BUF_EMPTY;
      post_q[0]     <= BUF_EMPTY;
      post_q[1]     <= BUF_EMPTY;
      c2p_idx       <= 1'b0;
      sc_idx        <= 1'b0;
      p2c_idx       <= 1'b0;
      scaler_win    <= 1'b0;
      p2c_buf       <= 1'b0;
      shift_amt_out <= 8'd0;
    end else begin
      if (c2p_accept) begin
        pre_q[c2p_idx] <= BUF_FULL;
        c2p_idx        <= ~c2p_idx;
      end
      if (sc_launch) begin
        pre_q[sc_idx]  <= BUF_BUSY;
        post_q[sc_idx] <= BUF_BUSY;
        scaler_win     <= sc_idx;
        shift_amt_out  <= shift_amt_in;
      end
      if (sc_finish) begin
        pre_q[sc_idx]  <= BUF_EMPTY;
        post_q[sc_idx] <= BUF_FULL;
        sc_idx         <= ~sc_idx;
      end
      if (pc_launch) begin
        post_q[p2c_idx] <= BUF_BUSY;
        p2c_buf         <= p2c_idx;
      end
      if (pc_finish) begin
        post_q[p2c_idx] <= BUF_EMPTY;
        p2c_idx         <= ~p2c_idx;
      end
    end
  end

`ifdef SCHED_STATS_EN
  logic c2p_drop;
  assign c2p_drop = c2p_done && !c2p_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      win_cnt  <= '0;
    end else begin
      if (c2p_drop && (drop_cnt != {CNT_W{1'b1}})) drop_cnt <= drop_cnt + 1'b1;
      if (pc_finish && (win_cnt != {CNT_W{1'b1}}))  win_cnt  <= win_cnt + 1'b1;
    end
  end
`else
  assign drop_cnt = '0;
  assign win_cnt  = '0;
`endif

endmodule

// File: tb/tb_pingpong_stage_sched.sv
// tb/tb_pingpong_stage_sched.sv - directed self-checking bench for pingpong_stage_sched
module tb_pingpong_stage_sched;

`ifdef SCHED_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       c2p_done;
  logic       c2p_ready;
  logic       c2p_idx;
  logic       scaler_go;
  logic       scaler_win;
  logic       scaler_done;
  logic [7:0] shift_amt_in;
  logic [7:0] shift_amt_out;
  logic       p2c_go;
  logic       p2c_buf;
  logic       p2c_done;
  logic [7:0] drop_cnt;
  logic [7:0] win_cnt;

  int checks;
  int errors;
  int sc_gos;
  int pc_gos;

  pingpong_stage_sched #(.CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .c2p_done      (c2p_done),
    .c2p_ready     (c2p_ready),
    .c2p_idx       (c2p_idx),
    .scaler_go     (scaler_go),
    .scaler_win    (scaler_win),
    .scaler_done   (scaler_done),
    .shift_amt_in  (shift_amt_in),
    .shift_amt_out (shift_amt_out),
    .p2c_go        (p2c_go),
    .p2c_buf       (p2c_buf),
    .p2c_done      (p2c_done),
    .drop_cnt      (drop_cnt),
    .win_cnt       (win_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_c2p_idx"}, c2p_idx, 0);
    check({tag, "_c2p_ready"}, c2p_ready, 1);
    check({tag, "_scaler_go"}, scaler_go, 0);
    check({tag, "_p2c_go"}, p2c_go, 0);
    check({tag, "_scaler_win"}, scaler_win, 0);
    check({tag, "_p2c_buf"}, p2c_buf, 0);
    check({tag, "_shift_out"}, shift_amt_out, 0);
    check({tag, "_drop_cnt"}, drop_cnt, 0);
    check({tag, "_win_cnt"}, win_cnt, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    c2p_done = 1'b0;
    scaler_done = 1'b0;
    p2c_done = 1'b0;
    shift_amt_in = 8'h00;
    tick();
    tick();
    check_reset_values("rst");
    rst_n = 1'b1;
    tick();

    // first window: go follows the accepted c2p_done by one clock
    shift_amt_in = 8'h05;
    c2p_done = 1'b1;
    tick();
    c2p_done = 1'b0;
    check("w0_c2p_idx", c2p_idx, 1);
    check("w0_ready", c2p_ready, 1);
    check("w0_go_early", scaler_go, 0);
    tick();
    check("w0_scaler_go", scaler_go, 1);
    check("w0_scaler_win", scaler_win, 0);
    check("w0_shift", shift_amt_out, 8'h05);
    shift_amt_in = 8'h0C;
    tick();
    check("w0_go_pulse", scaler_go, 0);
    check("w0_shift_hold", shift_amt_out, 8'h05);

    // second window fills pre1; third finds pre0 busy and drops
    c2p_done = 1'b1;
    tick();
    check("ovr_c2p_idx0", c2p_idx, 0);
    check("ovr_ready0", c2p_ready, 0);
    tick();
    c2p_done = 1'b0;
    check("ovr_c2p_idx", c2p_idx, 0);
    check("ovr_ready", c2p_ready, 0);
    check("ovr_drop", drop_cnt, STATS ? 1 : 0);
    check("ovr_no_go", scaler_go, 0);
    check("ovr_shift_hold", shift_amt_out, 8'h05);

    // scaler finishes window 0: p2c and scaler window 1 both start next clock
    scaler_done = 1'b1;
    tick();
    scaler_done = 1'b0;
    check("sd0_ready", c2p_ready, 1);
    check("sd0_no_p2c", p2c_go, 0);
    tick();
    check("sd0_p2c_go", p2c_go, 1);
    check("sd0_p2c_buf", p2c_buf, 0);
    check("sd0_sc_go", scaler_go, 1);
    check("sd0_sc_win", scaler_win, 1);
    check("sd0_shift", shift_amt_out, 8'h0C);
    tick();

    // scaler_done and c2p_done together: pre0 filled, post1 filled
    scaler_done = 1'b1;
    c2p_done = 1'b1;
    tick();
    scaler_done = 1'b0;
    c2p_done = 1'b0;
    check("dual_c2p_idx", c2p_idx, 1);
    check("dual_ready", c2p_ready, 1);
    check("dual_drop", drop_cnt, STATS ? 1 : 0);
    tick();
    check("dual_post0_busy", scaler_go, 0);
    check("dual_p2c_busy", p2c_go, 0);

    // freeing post0 allows the scaler only one clock later
    p2c_done = 1'b1;
    tick();
    p2c_done = 1'b0;
    check("free_not_same", scaler_go, 0);
    check("free_win", win_cnt, STATS ? 1 : 0);
    tick();
    check("free_sc_go", scaler_go, 1);
    check("free_sc_win", scaler_win, 0);
    check("free_p2c_go", p2c_go, 1);
    check("free_p2c_buf", p2c_buf, 1);
    tick();

    scaler_done = 1'b1;
    p2c_done = 1'b1;
    tick();
    scaler_done = 1'b0;
    p2c_done = 1'b0;
    check("drain_win", win_cnt, STATS ? 2 : 0);
    tick();
    check("drain_p2c_go", p2c_go, 1);
    check("drain_p2c_buf", p2c_buf, 0);
    check("drain_sc_win_hold", scaler_win, 0);
    p2c_done = 1'b1;
    tick();
    p2c_done = 1'b0;
    check("drain_win3", win_cnt, STATS ? 3 : 0);

    // stray dones while idle
    scaler_done = 1'b1;
    p2c_done = 1'b1;
    tick();
    scaler_done = 1'b0;
    p2c_done = 1'b0;
    tick();
    check("stray_sc_go", scaler_go, 0);
    check("stray_p2c_go", p2c_go, 0);
    check("stray_win", win_cnt, STATS ? 3 : 0);
    check("stray_ready", c2p_ready, 1);

    // reset while the scaler is busy, then a stray scaler_done
    c2p_done = 1'b1;
    tick();
    c2p_done = 1'b0;
    tick();
    check("mid_sc_go", scaler_go, 1);
    check("mid_sc_win", scaler_win, 1);
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    tick();
    rst_n = 1'b1;
    scaler_done = 1'b1;
    tick();
    scaler_done = 1'b0;
    check_reset_values("post_rst");
    tick();
    check("post_rst_sc_go", scaler_go, 0);
    check("post_rst_p2c_go", p2c_go, 0);

    // 300 back-to-back windows; counter must stick at 255
    sc_gos = 0;
    pc_gos = 0;
    for (int i = 0; i < 300; i++) begin
      c2p_done = 1'b1;
      tick();
      c2p_done = 1'b0;
      tick();
      if (scaler_go) sc_gos++;
      scaler_done = 1'b1;
      tick();
      scaler_done = 1'b0;
      tick();
      if (p2c_go) pc_gos++;
      p2c_done = 1'b1;
      tick();
      p2c_done = 1'b0;
      if (i == 0)   check("sat_win_first", win_cnt, STATS ? 1 : 0);
      if (i == 254) check("sat_win_255", win_cnt, STATS ? 255 : 0);
    end
    check("sat_sc_gos", sc_gos, 300);
    check("sat_pc_gos", pc_gos, 300);
    check("sat_win_final", win_cnt, STATS ? 255 : 0);
    check("sat_drop", drop_cnt, 0);
    check("sat_ready", c2p_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pingpong_stage_sched.md
PINGPONG_STAGE_SCHED -- requirements
Module: pingpong_stage_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the statistics counters.
REQ-002 SHALL have ports clk input 1 (system clock) and rst_n input 1 (reset, asynchronous, active-low).
REQ-003 SHALL have port c2p_done input 1: cart_to_polar finished writing the current pre-scaler buffer (1-cycle pulse).
REQ-004 SHALL have port c2p_ready output 1: the pre-scaler buffer at c2p_idx is EMPTY and may be written.
REQ-005 SHALL have port c2p_idx output 1: pre-scaler buffer cart_to_polar writes next.
REQ-006 SHALL have ports scaler_go output 1 (start pulse) and scaler_win output 1 (buffer index, drives scaler cur_window).
REQ-007 SHALL have port scaler_done input 1: scaler finished (its go_out rising, 1-cycle pulse).
REQ-008 SHALL have ports shift_amt_in input 8 (from software_interface) and shift_amt_out output 8 (to scaler).
REQ-009 SHALL have ports p2c_go output 1, p2c_buf output 1 (post-scaler buffer index), p2c_done input 1 (pulse).
REQ-010 SHALL have ports drop_cnt output CNT_W and win_cnt output CNT_W (statistics).

Function
REQ-011 SHALL keep a 2-bit state per buffer (pre0, pre1, post0, post1): EMPTY, FULL, BUSY.
REQ-012 SHALL keep pointers c2p_idx, sc_idx, p2c_idx, each toggling after use, so windows are processed strictly in order 0,1,0,1.
REQ-013 SHALL, on c2p_done with pre[c2p_idx]==EMPTY, set pre[c2p_idx]=FULL and toggle c2p_idx next cycle.
REQ-014 SHALL, on c2p_done with pre[c2p_idx]!=EMPTY (overrun), leave buffer states and c2p_idx unchanged and count a drop.
REQ-015 SHALL have scaler FSM SC_IDLE/SC_BUSY: SC_IDLE->SC_BUSY when pre[sc_idx]==FULL and post[sc_idx]==EMPTY; that cycle registers scaler_go=1 for exactly one cycle, scaler_win=sc_idx, shift_amt_out=shift_amt_in, pre[sc_idx]=BUSY, post[sc_idx]=BUSY.
REQ-016 SHALL, in SC_BUSY on scaler_done, set pre[sc_idx]=EMPTY, post[sc_idx]=FULL, toggle sc_idx, return to SC_IDLE; scaler_done in SC_IDLE is ignored.
REQ-017 SHALL have p2c FSM PC_IDLE/PC_BUSY: PC_IDLE->PC_BUSY when post[p2c_idx]==FULL, registering p2c_go=1 one cycle, p2c_buf=p2c_idx, post[p2c_idx]=BUSY.
REQ-018 SHALL, in PC_BUSY on p2c_done, set post[p2c_idx]=EMPTY, toggle p2c_idx, return to PC_IDLE, increment win_cnt; p2c_done in PC_IDLE is ignored.
REQ-019 SHALL evaluate start conditions on registered state only: minimum latency from c2p_done to scaler_go is 1 cycle, from scaler_done to p2c_go is 1 cycle.
REQ-020 SHALL process c2p_done, scaler_done and p2c_done in the same cycle independently; a freed buffer is reusable from the next cycle only.
REQ-021 SHALL hold scaler_win, p2c_buf and shift_amt_out stable between go pulses.
REQ-022 SHALL derive c2p_ready combinationally from pre[c2p_idx]==EMPTY.
REQ-023 SHALL saturate drop_cnt and win_cnt at all-ones.

Reset
REQ-024 SHALL on rst_n low asynchronously force all buffers EMPTY, all pointers 0, both FSMs IDLE, scaler_go=0, p2c_go=0, scaler_win=0, p2c_buf=0, shift_amt_out=0, drop_cnt=0, win_cnt=0.
REQ-025 SHALL, on reset mid-operation, abandon in-flight windows; done pulses arriving after reset release while IDLE are ignored.

Configuration
REQ-026 SHALL, with SCHED_STATS_EN defined, implement drop_cnt and win_cnt per REQ-014/018/023.
REQ-027 SHALL, without SCHED_STATS_EN, keep both ports but tie them to 0 with no counter registers.

Structure
REQ-028 SHALL place buffer-state enum (EMPTY/FULL/BUSY) and FSM state enums in shared package pitch_sched_pkg.
REQ-029 SHALL implement the start/done handshake of one stage as sub-module stage_handshake, instantiated twice (scaler, p2c).

Verification
REQ-030 SHALL cover: c2p_done at cycle 10 -> scaler_go at 11, scaler_win=0, c2p_idx=1, c2p_ready=1.
REQ-031 SHALL cover: shift_amt_in=0x05 at go, changed to 0x0C mid-window -> shift_amt_out stays 0x05 until next scaler_go.
REQ-032 SHALL cover: three c2p_done with no scaler_done -> third drops, drop_cnt=1, c2p_ready=0.
REQ-033 SHALL cover: scaler_done and c2p_done same cycle, post1 FULL -> pre0 FULL, post0 FULL, p2c_go next cycle with p2c_buf=0.
REQ-034 SHALL cover: rst_n low while SC_BUSY, then stray scaler_done -> all outputs at reset values, no go pulse.
REQ-035 SHALL cover: 300 full windows with CNT_W=8 -> win_cnt=255 saturated; without SCHED_STATS_EN -> 0.
